// File: rtl/tim_apb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tim_apb_ctrl
// Description : APB slave-side controller for the timer peripheral. It turns
//               every APB transfer into a single-cycle write or read strobe
//               toward the timer register bank and its read-data mux. It
//               inserts wait states, captures the address, data and strobes,
//               registers the read data and generates the error response.
//
//               Register map: TCR 0x00, TDR0 0x04, TDR1 0x08, TCMP0 0x0C,
//               TCMP1 0x10, TIER 0x14, TISR 0x18.
//
// Parameters  : ADDR_W       - width of tim_paddr (2..32)
//               WAIT_CYCLES  - APB wait states, 1..15
//
// Build macro : TIM_PSLVERR_EN - when defined, misaligned, out-of-map and
//               zero-strobe write accesses complete with tim_pslverr=1 and
//               issue no strobe. When undefined, tim_pslverr is tied to 0.
//
// Ports       : sys_clk, sys_rst_n      clock, async active-low reset
//               tim_psel/penable/pwrite APB control
//               tim_paddr/pwdata/pstrb  APB address, write data, strobes
//               tim_pready/prdata/
//               tim_pslverr             APB response (valid in DONE only)
//               reg_addr/wdata/wstrb    captured transfer toward the bank
//               wr_en, rd_en            one-cycle strobes toward the bank
//               rdata                   read-mux output
//
// Revision    : 1.0 - initial release
// ============================================================================
module tim_apb_ctrl #(
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              tim_psel,
    input  logic              tim_penable,
    input  logic              tim_pwrite,
    input  logic [ADDR_W-1:0] tim_paddr,
    input  logic [31:0]       tim_pwdata,
    input  logic [3:0]        tim_pstrb,
    output logic              tim_pready,
    output logic [31:0]       tim_prdata,
    output logic              tim_pslverr,
    output logic [31:0]       reg_addr,
    output logic [31:0]       reg_wdata,
    output logic [3:0]        reg_wstrb,
    output logic              wr_en,
    output logic              rd_en,
    input  logic [31:0]       rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_STROBE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] c_cnt_load = 4'(WAIT_CYCLES - 1);
    localparam bit         c_no_wait  = (WAIT_CYCLES == 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        r_write;
    logic        r_err;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [31:0] r_prdata;

    logic        w_setup;
    logic        w_active;
    logic        w_err;
    logic [31:0] w_addr_ext;

    assign w_setup  = tim_psel & ~tim_penable;
    assign w_active = tim_psel & tim_penable;

    always_comb begin
        w_addr_ext               = '0;
        w_addr_ext[ADDR_W-1:0]   = tim_paddr;
    end

`ifdef TIM_PSLVERR_EN
    assign w_err = (w_addr_ext[1:0] != 2'b00) ||
                   (w_addr_ext > 32'h0000_0018) ||
                   (tim_pwrite && (tim_pstrb == 4'h0));
`else
    assign w_err = 1'b0;
`endif

    // The counter holds the remaining WAIT cycles including the current one,
    // so leaving WAIT when it is at 1 lands STROBE exactly in cycle W.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_setup) begin
                    w_cnt_nxt   = c_cnt_load;
                    w_state_nxt = c_no_wait ? S_STROBE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!w_active) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else if (r_cnt <= 4'd1) begin
                    w_state_nxt = S_STROBE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            S_STROBE: begin
                // An abort during STROBE still lets the strobe of this cycle
                // through; only the completion is suppressed.
                w_state_nxt = w_active ? S_DONE : S_IDLE;
            end
            S_DONE: begin
                // A setup phase seen here is ignored.
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_write  <= 1'b0;
            r_err    <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_prdata <= '0;
        end else begin
            if ((r_state == S_IDLE) && w_setup) begin
                r_write <= tim_pwrite;
                r_err   <= w_err;
                r_addr  <= w_addr_ext;
                r_wdata <= tim_pwdata;
                r_wstrb <= tim_pstrb;
            end
            if (r_state == S_STROBE) begin
                r_prdata <= rdata;
            end
        end
    end

    assign wr_en      = (r_state == S_STROBE) &  r_write & ~r_err;
    assign rd_en      = (r_state == S_STROBE) & ~r_write & ~r_err;
    assign tim_pready = (r_state == S_DONE);
    assign tim_prdata = (tim_pready & ~r_write & ~r_err) ? r_prdata : 32'h0;
`ifdef TIM_PSLVERR_EN
    assign tim_pslverr = tim_pready & r_err;
`else
    assign tim_pslverr = 1'b0;
`endif

    assign reg_addr  = r_addr;
    assign reg_wdata = r_wdata;
    assign reg_wstrb = r_wstrb;

endmodule
`default_nettype wire

// File: tb/tb_tim_apb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tim_apb_ctrl
// Description : Self-checking bench for tim_apb_ctrl. Two instances are used,
//               index 0 with WAIT_CYCLES=1 and index 1 with WAIT_CYCLES=3.
//               Expected completions are pushed to a scoreboard queue when a
//               transfer is issued and popped when tim_pready is observed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tim_apb_ctrl;

    typedef struct {
        logic [31:0] prdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [11:0] paddr   [2];
    logic [31:0] pwdata  [2];
    logic [3:0]  pstrb   [2];
    logic [31:0] rdata   [2];
    logic        pready  [2];
    logic        pslverr [2];
    logic [31:0] prdata  [2];
    logic [31:0] reg_addr  [2];
    logic [31:0] reg_wdata [2];
    logic [3:0]  reg_wstrb [2];
    logic        wr_en   [2];
    logic        rd_en   [2];

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    tim_apb_ctrl #(.ADDR_W(12), .WAIT_CYCLES(1)) u_dut_w1 (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .tim_psel(psel[0]), .tim_penable(penable[0]), .tim_pwrite(pwrite[0]),
        .tim_paddr(paddr[0]), .tim_pwdata(pwdata[0]), .tim_pstrb(pstrb[0]),
        .tim_pready(pready[0]), .tim_prdata(prdata[0]), .tim_pslverr(pslverr[0]),
        .reg_addr(reg_addr[0]), .reg_wdata(reg_wdata[0]), .reg_wstrb(reg_wstrb[0]),
        .wr_en(wr_en[0]), .rd_en(rd_en[0]), .rdata(rdata[0])
    );

    tim_apb_ctrl #(.ADDR_W(12), .WAIT_CYCLES(3)) u_dut_w3 (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .tim_psel(psel[1]), .tim_penable(penable[1]), .tim_pwrite(pwrite[1]),
        .tim_paddr(paddr[1]), .tim_pwdata(pwdata[1]), .tim_pstrb(pstrb[1]),
        .tim_pready(pready[1]), .tim_prdata(prdata[1]), .tim_pslverr(pslverr[1]),
        .reg_addr(reg_addr[1]), .reg_wdata(reg_wdata[1]), .reg_wstrb(reg_wstrb[1]),
        .wr_en(wr_en[1]), .rd_en(rd_en[1]), .rdata(rdata[1])
    );

    function automatic int wait_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Error model: misaligned, beyond TISR (0x18), or a write with no strobes.
    function automatic logic exp_err(input logic wr, input logic [11:0] a, input logic [3:0] s);
`ifdef TIM_PSLVERR_EN
        logic [11:0] aa;
        aa = a;
        return (aa[1:0] != 2'b00) || (aa > 12'h018) || (wr && (s == 4'h0));
`else
        return 1'b0;
`endif
    endfunction

    // One full transfer on DUT d. Cycle 0 is the setup phase; the task
    // returns after sampling the DONE cycle with the bus still in ACCESS, so
    // a following call places its setup phase in cycle W+2.
    task automatic xfer(input int d, input logic wr, input logic [11:0] addr,
                        input logic [31:0] wd, input logic [3:0] st,
                        input logic [31:0] rv, input string name);
        int   w;
        int   wr_cnt;
        int   rd_cnt;
        int   stb_cyc;
        int   done_cyc;
        logic er;
        exp_t e;
        exp_t got;
        w        = wait_of(d);
        wr_cnt   = 0;
        rd_cnt   = 0;
        stb_cyc  = -1;
        done_cyc = -1;
        er       = exp_err(wr, addr, st);
        e.prdata = (wr || er) ? 32'h0 : rv;
        e.err    = er;
        sb.push_back(e);

        @(posedge clk); #1;
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
        paddr[d] = addr; pwdata[d] = wd; pstrb[d] = st; rdata[d] = rv;
        @(negedge clk);
        n_total++;
        if ({pready[d], prdata[d], wr_en[d], rd_en[d]} !== 35'h0)
            $display("FAIL %s idle: pready=%b prdata=%h wr_en=%b rd_en=%b, required all 0",
                     name, pready[d], prdata[d], wr_en[d], rd_en[d]);
        else n_pass++;
        @(posedge clk); #1;
        penable[d] = 1'b1;

        for (int c = 1; c <= w + 4; c++) begin
            if (done_cyc < 0) begin
                @(negedge clk);
                if (wr_en[d]) begin wr_cnt++; stb_cyc = c; end
                if (rd_en[d]) begin rd_cnt++; stb_cyc = c; end
                if (c == w) begin
                    n_total++;
                    if ({reg_addr[d], reg_wdata[d], reg_wstrb[d]} !== {20'h0, addr, wd, st})
                        $display("FAIL %s capture: addr=%h wdata=%h wstrb=%h, required %h %h %h",
                                 name, reg_addr[d], reg_wdata[d], reg_wstrb[d], {20'h0, addr}, wd, st);
                    else n_pass++;
                end
                if (pready[d]) begin
                    done_cyc = c;
                    got.prdata = prdata[d];
                    got.err    = pslverr[d];
                    e = sb.pop_front();
                    n_total++;
                    if ({got.prdata, got.err} !== {e.prdata, e.err})
                        $display("FAIL %s response: prdata=%h pslverr=%b, required %h %b",
                                 name, got.prdata, got.err, e.prdata, e.err);
                    else n_pass++;
                end
            end
        end

        n_total++;
        if (done_cyc != w + 1)
            $display("FAIL %s latency: pready in cycle %0d, required cycle %0d", name, done_cyc, w + 1);
        else n_pass++;

        n_total++;
        if ((wr_cnt != ((wr && !er) ? 1 : 0)) || (rd_cnt != ((!wr && !er) ? 1 : 0)) ||
            (stb_cyc != (er ? -1 : w)))
            $display("FAIL %s strobe: wr_cnt=%0d rd_cnt=%0d cycle=%0d, required wr=%0d rd=%0d cycle=%0d",
                     name, wr_cnt, rd_cnt, stb_cyc, (wr && !er) ? 1 : 0, (!wr && !er) ? 1 : 0,
                     er ? -1 : w);
        else n_pass++;
    endtask

    // Return the bus to idle and check the response has dropped.
    task automatic bus_idle(input int d, input string name);
        @(posedge clk); #1;
        psel[d] = 1'b0; penable[d] = 1'b0;
        @(negedge clk);
        n_total++;
        if ({pready[d], pslverr[d], prdata[d]} !== 34'h0)
            $display("FAIL %s after-done: pready=%b pslverr=%b prdata=%h, required all 0",
                     name, pready[d], pslverr[d], prdata[d]);
        else n_pass++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if ({pready[d], pslverr[d], wr_en[d], rd_en[d], prdata[d],
                 reg_addr[d], reg_wdata[d], reg_wstrb[d]} !== 104'h0)
                $display("FAIL reset_state dut%0d: pready=%b wr_en=%b rd_en=%b prdata=%h reg_addr=%h, required all 0",
                         d, pready[d], wr_en[d], rd_en[d], prdata[d], reg_addr[d]);
            else n_pass++;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_write_w1;
        xfer(0, 1'b1, 12'h000, 32'hA5A5_0001, 4'hF, 32'h0, "write_w1");
    endtask

    task automatic test_read_w1;
        xfer(0, 1'b0, 12'h014, 32'h0, 4'h0, 32'h0000_0003, "read_w1");
        bus_idle(0, "read_w1");
    endtask

    task automatic test_wait_states;
        xfer(1, 1'b0, 12'h004, 32'h0, 4'h0, 32'h0000_BEEF, "wait_read0");
        xfer(1, 1'b0, 12'h00C, 32'h0, 4'h0, 32'h55AA_0F0F, "wait_read1");
        bus_idle(1, "wait_read1");
    endtask

    task automatic test_abort;
        int bad;
        bad = 0;
        @(posedge clk); #1;
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 12'h008; pwdata[1] = 32'h0BAD_0BAD; pstrb[1] = 4'hF;
        @(negedge clk);
        @(posedge clk); #1;
        penable[1] = 1'b1;
        @(negedge clk);
        if (wr_en[1] || rd_en[1] || pready[1]) bad++;
        @(posedge clk); #1;
        psel[1] = 1'b0; penable[1] = 1'b0;
        @(negedge clk);
        if (wr_en[1] || rd_en[1] || pready[1]) bad++;
        n_total++;
        if (bad != 0)
            $display("FAIL abort: %0d cycles with strobe or pready, required 0", bad);
        else n_pass++;
        // New setup in cycle 3; its idle check also covers cycle 3 of the abort.
        xfer(1, 1'b1, 12'h010, 32'hCAFE_F00D, 4'h3, 32'h0, "after_abort");
        bus_idle(1, "after_abort");
    endtask

    task automatic test_errors;
        xfer(0, 1'b0, 12'h01C, 32'h0, 4'h0, 32'h0, "err_rd_1c");
        xfer(0, 1'b1, 12'h006, 32'h1111_2222, 4'hF, 32'h0, "err_wr_06");
        xfer(0, 1'b1, 12'h000, 32'h3333_4444, 4'h0, 32'h0, "err_wr_strb0");
        bus_idle(0, "err_wr_strb0");
        xfer(1, 1'b0, 12'h018, 32'h0, 4'h0, 32'h0000_00A5, "rd_tisr_w3");
        bus_idle(1, "rd_tisr_w3");
    endtask

    task automatic test_reset_mid_strobe;
        @(posedge clk); #1;
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
        paddr[0] = 12'h010; pwdata[0] = 32'h1234_5678; pstrb[0] = 4'hC;
        @(posedge clk); #1;
        penable[0] = 1'b1;
        n_total++;
        if ({wr_en[0], reg_addr[0]} !== {1'b1, 32'h10})
            $display("FAIL mid_reset_pre: wr_en=%b reg_addr=%h, required 1 00000010", wr_en[0], reg_addr[0]);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({pready[0], pslverr[0], wr_en[0], rd_en[0], prdata[0],
             reg_addr[0], reg_wdata[0], reg_wstrb[0]} !== 104'h0)
            $display("FAIL mid_reset: wr_en=%b pready=%b prdata=%h reg_addr=%h reg_wdata=%h reg_wstrb=%h, required all 0",
                     wr_en[0], pready[0], prdata[0], reg_addr[0], reg_wdata[0], reg_wstrb[0]);
        else n_pass++;
        psel[0] = 1'b0; penable[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if ({pready[0], wr_en[0], rd_en[0]} !== 3'b000)
            $display("FAIL mid_reset_release: pready=%b wr_en=%b rd_en=%b, required 0 0 0",
                     pready[0], wr_en[0], rd_en[0]);
        else n_pass++;
        xfer(0, 1'b0, 12'h008, 32'h0, 4'h0, 32'h7777_1234, "post_reset_rd");
        bus_idle(0, "post_reset_rd");
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
            paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0; rdata[d] = '0;
        end
        test_reset();
        test_write_w1();
        test_read_w1();
        test_wait_states();
        test_abort();
        test_errors();
        test_reset_mid_strobe();
        n_total++;
        if (sb.size() != 0)
            $display("FAIL scoreboard: %0d completions outstanding, required 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tim_apb_ctrl.md
# tim_apb_ctrl

APB slave-side controller for the timer peripheral. It sequences every APB transfer into a single-cycle write or read strobe toward the timer register bank and its read-data mux. The register map is TCR 0x00, TDR0 0x04, TDR1 0x08, TCMP0 0x0C, TCMP1 0x10, TIER 0x14 and TISR 0x18. The block sits between the bus fabric and the register bank. It owns wait-state insertion, capture of address, data and strobes, read-data registration and error response.

## Interface
Parameters:
- ADDR_W, 12, width of tim_paddr
- WAIT_CYCLES, 1, number of APB wait states; legal range 1..15

Ports:
- sys_clk  in  1  system clock; all logic is rising-edge
- sys_rst_n  in  1  asynchronous, active-low reset
- tim_psel  in  1  APB select
- tim_penable  in  1  APB enable
- tim_pwrite  in  1  1 = write, 0 = read
- tim_paddr  in  ADDR_W  byte address
- tim_pwdata  in  32  write data
- tim_pstrb  in  4  write byte strobes
- tim_pready  out  1  transfer complete
- tim_prdata  out  32  read data; valid only while tim_pready=1
- tim_pslverr  out  1  error response; valid only while tim_pready=1
- reg_addr  out  32  captured address, zero-extended
- reg_wdata  out  32  captured write data
- reg_wstrb  out  4  captured byte strobes
- wr_en  out  1  one-cycle write strobe to the register bank
- rd_en  out  1  one-cycle read enable to the read mux
- rdata  in  32  read-mux output; combinational from reg_addr and rd_en

## Operation
- Cycle 0 is the setup phase, defined as tim_psel=1 and tim_penable=0 sampled in IDLE. At the end of cycle 0 the block:
  - captures tim_paddr, tim_pwdata, tim_pstrb and tim_pwrite;
  - evaluates the error condition;
  - loads the wait counter with WAIT_CYCLES-1.
- FSM states and transitions:
  - IDLE → WAIT on a setup phase.
  - WAIT → STROBE when the counter reaches 0; otherwise the counter decrements each cycle.
  - STROBE → DONE.
  - DONE → IDLE.
  - With WAIT_CYCLES=1, WAIT lasts 0 cycles and the path is IDLE → STROBE directly.
- STROBE, cycle W (W = WAIT_CYCLES):
  - wr_en=1 on a captured write, or rd_en=1 on a captured read, for exactly that cycle.
  - Neither strobe is raised if an error was flagged.
  - rdata is registered into the prdata holding register at the end of this cycle.
- DONE, cycle W+1: tim_pready=1 and tim_pslverr reflects the error flag. tim_prdata carries:
  - the held value for a read;
  - 0 for a write or an error.
- Outside DONE, tim_pready, tim_pslverr and tim_prdata are all 0.
- Abort: if tim_psel or tim_penable is 0 in any cycle from 1 up to and including W:
  - the FSM returns to IDLE on the next edge;
  - no strobe is issued, or the in-flight strobe cycle is the last one;
  - tim_pready is never raised.
- Back-to-back transfers: the earliest next setup phase is cycle W+2, sampled in IDLE. A setup phase presented during DONE is ignored, as the APB protocol requires.
- reg_addr, reg_wdata and reg_wstrb hold their last captured values until the next setup phase.

## Timing
- Reset: all outputs and internal state are forced to 0 asynchronously, and the FSM goes to IDLE. This applies mid-transfer too, including during STROBE, where wr_en drops immediately.
- Strobe latency: W cycles after the setup phase.
- Completion latency: W+1 cycles after the setup phase, with exactly W cycles where tim_penable=1 and tim_pready=0.
- Write visibility: the register bank commits on the edge that ends STROBE, so a read issued immediately afterwards returns the new value.
- Address arithmetic: reg_addr = {zeros, tim_paddr}. There is no wrap and no offset.

## Configuration
- TIM_PSLVERR_EN defined:
  - The error condition is tim_paddr[1:0]≠0, or tim_paddr>0x18, or (write and tim_pstrb==0).
  - On error: no strobe, tim_pslverr=1 in DONE, tim_prdata=0.
- TIM_PSLVERR_EN undefined:
  - tim_pslverr is tied to 0 and no error is ever flagged.
  - All transfers issue their strobe, so out-of-map reads return the mux default of 0.

## Test plan
- Reset: assert sys_rst_n=0 in the middle of STROBE → wr_en, rd_en, tim_pready, tim_prdata, tim_pslverr and reg_* are all 0 immediately, and the FSM is in IDLE after release.
- Write, W=1: write 0xA5A50001 to 0x00 with strb 0xF → in cycle 1 wr_en=1, reg_addr=0x0 and reg_wdata=0xA5A50001; in cycle 2 tim_pready=1 and tim_pslverr=0.
- Read, W=1: read 0x14 with rdata driven 0x00000003 → rd_en=1 in cycle 1 only; tim_prdata=0x00000003 with tim_pready=1 in cycle 2; tim_prdata=0 in cycle 3.
- Wait states, W=3: read 0x04 → rd_en only in cycle 3, tim_pready only in cycle 4. A second setup phase in cycle 5 completes in cycle 9.
- Errors with TIM_PSLVERR_EN:
  - read 0x1C, write 0x06, and write 0x00 with strb 0x0 → no wr_en or rd_en, tim_pslverr=1 and tim_prdata=0 in cycle W+1;
  - without the macro, the 0x1C read raises rd_en and completes with tim_pslverr=0.
- Abort, W=3: drop tim_psel in cycle 2 → no strobe, tim_pready never asserted, and a new setup phase in cycle 3 is accepted.
